// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch unit with a small FIFO between the instruction
//            memory and decode. Each free cycle it fetches the word at
//            fetch_pc, queues {pc, instr} and advances fetch_pc by 4. A
//            redirect flushes the queue and restarts fetching at the target.
// Ports    :
//   clk            - single clock, rising edge
//   reset          - synchronous, active-high reset
//   imem_addr      - byte address presented to instruction memory (= fetch_pc)
//   imem_data      - instruction word for imem_addr, same cycle
//   redirect_valid - branch/jump redirect request (flushes queue)
//   redirect_pc    - redirect target byte address (low two bits ignored)
//   out_valid      - queue head holds an instruction for decode
//   out_ready      - decode accepts the head this cycle
//   out_instr      - instruction word at queue head (0 when not valid)
//   out_pc         - byte address of out_instr (0 when not valid)
//   count          - number of occupied entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic             pop;
  logic             push;

  // The two low target bits are forced to zero when loaded into fetch_pc.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  assign imem_addr = fetch_pc;

  // A redirect cycle hides the head so decode can never consume a stale
  // instruction in the same cycle the queue is flushed.
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  // A full queue may still accept a new entry when the head leaves this cycle.
  assign push      = !redirect_valid && ((count < FULL_COUNT) || pop);

  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;

  // Control state: fetch address, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the queue entry count (power of two, 2..16).
REQ-003 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL provide port imem_addr, output, 32 bits: byte address presented to the instruction memory.
REQ-006 The block SHALL provide port imem_data, input, 32 bits: instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 The block SHALL provide port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 The block SHALL provide port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 The block SHALL provide port out_valid, output, 1 bit: the queue head holds an instruction for decode.
REQ-010 The block SHALL provide port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 The block SHALL provide port out_instr, output, 32 bits: instruction word at the queue head.
REQ-012 The block SHALL provide port out_pc, output, 32 bits: byte address of out_instr.
REQ-013 The block SHALL provide port count, output, clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-014 The block SHALL hold a 32-bit register fetch_pc and drive imem_addr = fetch_pc continuously.
REQ-015 A pop SHALL occur when out_valid=1 and out_ready=1; it removes the head entry at the clock edge.
REQ-016 A push SHALL occur when redirect_valid=0 and (count<DEPTH or a pop occurs this cycle); it writes {fetch_pc, imem_data} at the tail and sets fetch_pc <= fetch_pc+4.
REQ-017 With count=DEPTH and no pop, the block SHALL NOT push and SHALL hold fetch_pc.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-019 out_valid SHALL equal (count!=0) and redirect_valid=0; out_instr and out_pc SHALL read 0 whenever out_valid=0.
REQ-020 A cycle with redirect_valid=1 SHALL set count<=0, discard all entries, perform no push, and load fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-021 Because out_valid=0 during a redirect cycle, no pop SHALL occur in that cycle regardless of out_ready.
REQ-022 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Latency SHALL be one cycle: an instruction pushed at edge N is visible on out_instr/out_pc with out_valid=1 after edge N.
REQ-025 With out_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle with consecutive out_pc values.

Reset
REQ-026 On a clock edge with reset=1, the block SHALL set fetch_pc=RESET_PC, count=0, both pointers=0; out_valid, out_instr and out_pc SHALL read 0.
REQ-027 reset SHALL take priority over redirect_valid, push and pop in the same cycle, including mid-stream with the queue partially full.
REQ-028 Queue storage need not be cleared by reset.

Verification
REQ-029 The bench SHALL apply reset, then release with out_ready=1 and memory word = address: out_pc = 0,4,8,12 on consecutive cycles from the first cycle after release, with out_instr = out_pc.
REQ-030 The bench SHALL release reset with out_ready=0 and DEPTH=4: count reaches 4 after 4 cycles, imem_addr holds 16 thereafter, then one out_ready pulse yields out_pc=0 and count stays 4.
REQ-031 The bench SHALL apply redirect_valid=1 with redirect_pc=32'h0000_0103 while count=3: out_valid=0 in that cycle, count=0 next cycle, then out_pc=32'h0000_0100 one cycle later.
REQ-032 The bench SHALL load redirect_pc=32'hFFFF_FFF8 with out_ready=1: out_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 The bench SHALL assert reset and redirect_valid together with the queue full: the next cycle shows count=0, imem_addr=RESET_PC, out_valid=0.
